// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load marker bit in ResultSrc, and the multi-cycle FSM state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int RESULTSRC_LOAD_BIT = 0;

    typedef enum logic {
        MC_IDLE,
        MC_BUSY
    } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_mc_stall.sv
// Multi-cycle execute occupancy tracker: an op of latency N seen in E at cycle t
// asserts mcStall for cycles t..t+N-2; the first stall cycle is combinational from McStartE.
module mc_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             McStartE,
    input  logic [LAT_W-1:0] McLatE,
    output logic             mcStall,
    output logic             McBusy
);

    mc_state_t        r_state;
    logic [LAT_W-1:0] r_cnt;
    int               w_lat;

    assign w_lat = 32'(McLatE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    // N==2 needs only the combinational first-cycle stall
                    if (McStartE && w_lat >= 3) begin
                        r_cnt   <= McLatE - LAT_W'(3);
                        r_state <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= MC_IDLE;
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                default: r_state <= MC_IDLE;
            endcase
        end
    end

    assign McBusy  = (r_state == MC_BUSY);
    assign mcStall = McBusy || (McStartE && w_lat >= 2);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage core: M/W forwarding, load-use stall, branch flush, mul/div stall.
// HAZARD_PERF_EN adds 32-bit event counters for lw/mc stalls and branch flushes.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 4,
    parameter bit FWD_W_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic [LAT_W-1:0]  McLatE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       PerfLwStall,
    output logic [31:0]       PerfMcStall,
    output logic [31:0]       PerfFlush
`endif
);

    logic w_mc_stall;
    logic w_mc_busy;
    logic w_lw_stall;
    logic w_branch;
    logic w_unused;

    mc_stall_ctrl #(.LAT_W(LAT_W)) u_mc (
        .clk      (clk),
        .reset    (reset),
        .McStartE (McStartE),
        .McLatE   (McLatE),
        .mcStall  (w_mc_stall),
        .McBusy   (w_mc_busy)
    );

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && rs == RdM && RegWriteM)
            return FWD_M;
        else if (FWD_W_EN && rs != '0 && rs == RdW && RegWriteW)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    assign w_lw_stall = ResultSrcE[RESULTSRC_LOAD_BIT] && RegWriteE && (RdE != '0) &&
                        ((Rs1D == RdE) || (Rs2D == RdE));
    // E holds the mul/div in these cases, so a branch indication there is bogus
    assign w_branch   = PCSrcE && !McStartE && !w_mc_busy;
    assign w_unused   = ^ResultSrcE;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            if (w_mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (w_lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (w_branch) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign McBusy = w_mc_busy && !reset;

`ifdef HAZARD_PERF_EN
    logic w_lw_win;
    logic w_mc_win;
    logic w_br_win;

    assign w_mc_win = w_mc_stall;
    assign w_lw_win = !w_mc_stall && w_lw_stall;
    assign w_br_win = !w_mc_stall && !w_lw_stall && w_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            PerfLwStall <= '0;
            PerfMcStall <= '0;
            PerfFlush   <= '0;
        end else begin
            if (w_lw_win) PerfLwStall <= PerfLwStall + 32'd1;
            if (w_mc_win) PerfMcStall <= PerfMcStall + 32'd1;
            if (w_br_win) PerfFlush   <= PerfFlush + 32'd1;
        end
    end
`endif

    a_no_branch_in_mc: assert property (@(posedge clk) disable iff (reset)
        !(PCSrcE && (McStartE || w_mc_busy)));

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, McStartE;
    logic [3:0] McLatE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] PerfLwStall, PerfMcStall, PerfFlush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wire [5:0] w_ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

    hazard_ctrl_mc dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .McStartE(McStartE), .McLatE(McLatE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy)
`ifdef HAZARD_PERF_EN
        , .PerfLwStall(PerfLwStall), .PerfMcStall(PerfMcStall), .PerfFlush(PerfFlush)
`endif
    );

    // ctl bit order: StallF StallD StallE FlushD FlushE FlushM
    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       wee, wem, wew;
        logic [1:0] rsrc;
        logic       pcs;
        logic [1:0] fa, fb;
        logic [5:0] ctl;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic wee, wem, wew, input logic [1:0] rsrc,
                                input logic pcs, input logic [1:0] fa, fb,
                                input logic [5:0] ctl);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.wee = wee; v.wem = wem; v.wew = wew;
        v.rsrc = rsrc; v.pcs = pcs; v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        RegWriteE = v.wee; RegWriteM = v.wem; RegWriteW = v.wew;
        ResultSrcE = v.rsrc; PCSrcE = v.pcs;
    endtask

    task automatic mc_run(input int n, input bit with_load, input string tag);
        logic [5:0] exp_ctl;
        bit stall, busy;
        for (int k = 0; k <= n + 1; k++) begin
            @(posedge clk); #1;
            McStartE = (k == 0) || (k <= n - 2);
            McLatE   = 4'(n);
            Rs1E = 5'd4; RdW = 5'd4; RegWriteW = 1'b1;
            if (with_load && k <= n - 1) begin
                ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
            end else begin
                ResultSrcE = 2'b00; RegWriteE = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
            end
            @(negedge clk);
            stall = (n >= 2) && (k <= n - 2);
            busy  = (k >= 1) && (k <= n - 2);
            if (stall)                     exp_ctl = 6'b111001;
            else if (with_load && k == n - 1) exp_ctl = 6'b110010;
            else                           exp_ctl = 6'b000000;
            chk($sformatf("%s ctl k%0d", tag, k), 32'(w_ctl), 32'(exp_ctl));
            chk($sformatf("%s busy k%0d", tag, k), 32'(McBusy), 32'(busy));
            chk($sformatf("%s fwdA k%0d", tag, k), 32'(ForwardAE), 32'(2'b01));
        end
        McStartE = 1'b0;
    endtask

    initial begin
        //             rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw  wE wM wW rsrc  pc  fa     fb     ctl
        vecs[0]  = mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 1, 2'b00, 0, 2'b10, 2'b00, 6'b000000);
        vecs[1]  = mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 0, 1, 2'b00, 0, 2'b01, 2'b00, 6'b000000);
        vecs[2]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 6'b000000);
        vecs[3]  = mk(5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 6'b000000);
        vecs[4]  = mk(5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 0, 1, 1, 2'b00, 0, 2'b10, 2'b10, 6'b000000);
        vecs[5]  = mk(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00, 6'b110010);
        vecs[6]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00, 6'b000000);
        vecs[7]  = mk(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 6'b000000);
        vecs[8]  = mk(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 6'b000000);
        vecs[9]  = mk(5'd7, 5'd0, 5'd0, 5'd2, 5'd7, 5'd2, 5'd0, 1, 1, 0, 2'b01, 0, 2'b00, 2'b10, 6'b110010);
        vecs[10] = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 6'b000110);
        vecs[11] = mk(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 0, 0, 2'b01, 1, 2'b00, 2'b00, 6'b110010);
        vecs[12] = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 6'b000000);

        reset = 1'b1;
        McStartE = 1'b0;
        McLatE = 4'd0;
        apply(vecs[0]);
        @(posedge clk);
        @(negedge clk);
        chk("reset ctl", 32'(w_ctl), 32'(6'b000111));
        chk("reset fwdA", 32'(ForwardAE), 32'(2'b00));
        chk("reset busy", 32'(McBusy), 32'(1'b0));

        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d fwdA", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("vec%0d fwdB", i), 32'(ForwardBE), 32'(vecs[i].fb));
            chk($sformatf("vec%0d ctl", i), 32'(w_ctl), 32'(vecs[i].ctl));
        end
        apply(vecs[12]);

        mc_run(5, 1'b0, "mc5");
        mc_run(2, 1'b0, "mc2");
        mc_run(1, 1'b0, "mc1");
        mc_run(4, 1'b1, "mc4lw");
        apply(vecs[12]);

        // reset lands on the second cycle of a 6-cycle op
        @(posedge clk); #1;
        McStartE = 1'b1; McLatE = 4'd6;
        Rs1E = 5'd4; RdW = 5'd4; RegWriteW = 1'b1;
        @(negedge clk);
        chk("rst-mid t ctl", 32'(w_ctl), 32'(6'b111001));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst-mid t+1 ctl", 32'(w_ctl), 32'(6'b000111));
        chk("rst-mid t+1 busy", 32'(McBusy), 32'(1'b0));
        chk("rst-mid t+1 fwdA", 32'(ForwardAE), 32'(2'b00));
        @(posedge clk); #1;
        reset = 1'b0;
        McStartE = 1'b0;
        @(negedge clk);
        chk("rst-mid t+2 ctl", 32'(w_ctl), 32'(6'b000000));
        chk("rst-mid t+2 busy", 32'(McBusy), 32'(1'b0));
        chk("rst-mid t+2 fwdA", 32'(ForwardAE), 32'(2'b01));
`ifdef HAZARD_PERF_EN
        chk("perf lw after reset", PerfLwStall, 32'd0);
        chk("perf mc after reset", PerfMcStall, 32'd0);
        chk("perf flush after reset", PerfFlush, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
